mem_responder: RTL and testbench
================================

# mem_responder

Single-port 16-bit word memory that answers the CPU's memory bus: it consumes `addr`, write data and `memory_w`, and it returns read data and `memory_ready` after a fixed, parameterised latency. It sits between the CPU and the on-chip RAM. The CPU holds its request until it sees `memory_ready`. The responder therefore runs a small capture/wait/ready state machine and never needs a separate request strobe.

## Interface
- `ADDR_W`, 16: implemented word-address bits. Depth is 2^ADDR_W words of 16 bits.
- `LATENCY`, 2: cycles from the capture cycle to the `memory_ready` cycle. Legal range is 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr` in 16: word address from the CPU.
- `wr_data` in 16: write data, connected to the CPU `out_data`.
- `memory_w` in 1: 1 = write, 0 = read.
- `memory_ready` out 1: one-cycle pulse indicating the access is complete.
- `rd_data` out 16: read data, connected to the CPU `in_data`. Valid only while `memory_ready`=1.
- `mem_error` out 1: out-of-range access flag, active in the `memory_ready` cycle only.

## Operation
- States are IDLE, WAIT and READY.
- **IDLE:** every cycle, capture `addr`, `wr_data` and `memory_w` into request registers. Load the counter with LATENCY-1. Go to READY if LATENCY=1, otherwise go to WAIT.
- **WAIT:** decrement the counter. Go to READY on the edge where the counter is 0. Bus inputs are ignored; only the captured values matter.
- **Transition into READY** (one edge does all of the following):
  - For a write, store the captured data at the captured address. Load `rd_data` with the captured write data.
  - For a read, load `rd_data` with the array word at the captured address.
  - Set `memory_ready`.
- **READY:** `memory_ready`=1 for exactly one cycle, then return to IDLE unconditionally.
- **No request strobe:** the responder re-captures the bus in every IDLE cycle. Repeated reads are harmless. A write held high after `memory_ready` is re-executed with identical address and data, so it is idempotent by construction.
- **Address mapping:** the array is indexed by `addr[ADDR_W-1:0]`.
- **Read-after-write:** an access captured after a write's READY cycle sees the new data.
- **Reset:**
  - Async, mid-operation included: state goes to IDLE, `memory_ready`=0, `rd_data`=16'h0000, `mem_error`=0, counter 0, request registers 0.
  - A pending write that has not yet reached READY is discarded.
  - Array contents are not reset.

## Timing
- Capture at edge E0 (the IDLE cycle, T). `memory_ready` and `rd_data` are valid during cycle T+LATENCY. The next capture is at T+LATENCY+1.
- Throughput is one access per LATENCY+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Counter width is 4 bits. LATENCY outside 1..15 is a static assertion failure.
- Reset values: `memory_ready`=0, `rd_data`=0, `mem_error`=0, state IDLE.
- The first capture happens in the first cycle after `rst_n` rises.

## Configuration
- Macro: `MEM_RESPONDER_RANGE_CHECK_EN`.
- **Defined:** an access with any nonzero `addr[15:ADDR_W]` is out of range.
  - A write is dropped, so the array is unchanged.
  - A read returns 16'hDEAD.
  - `mem_error`=1 alongside `memory_ready`.
  - Latency is unchanged.
- **Undefined:** upper address bits are ignored, so addresses alias modulo 2^ADDR_W. `mem_error` is tied to 0.
- With ADDR_W=16 both builds behave identically.

## Structure
- Package `mem_responder_pkg` holds:
  - the state enum `resp_state_t` (IDLE, WAIT, READY);
  - the constant `MEM_POISON` = 16'hDEAD;
  - the constant `LAT_CNT_W` = 4.
- Sub-module `mem_array`: synchronous single-port RAM with write enable, 2^ADDR_W x 16 and a registered read. The FSM, counter, request registers and range check live in `mem_responder`.

## Test plan
- **Reset mid-operation:** assert `rst_n`=0 while in WAIT with a pending write to 0x0010. `memory_ready`, `rd_data` and `mem_error` go to 0 immediately. A later read of 0x0010 returns its pre-write value.
- **LATENCY=2 write-then-read:**
  - Write 0x1234 to 0x0020 → `memory_ready` pulses at T+2 only.
  - Then read 0x0020 → `rd_data`=0x1234 during its `memory_ready` cycle.
- **LATENCY=1 back-to-back reads:** read 0xFFFF then 0xFFFE (stack addresses) → `memory_ready` every second cycle, each with the matching word.
- **Held write:** keep `memory_w`=1, `addr`=0x0030, `wr_data`=0x00AA for 10 cycles. Pulses repeat every LATENCY+1 cycles and the array word stays 0x00AA.
- **Range check** (`MEM_RESPONDER_RANGE_CHECK_EN`, ADDR_W=8):
  - Write 0x5555 to 0x0105 → `mem_error`=1, and location 0x05 is unchanged.
  - Read 0x0105 → `rd_data`=0xDEAD, `mem_error`=1.
- **Aliasing** (no macro, ADDR_W=8): write 0x7777 to 0x0105, then read 0x0005 → 0x7777, `mem_error`=0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder CPU memory-bus slave.
package mem_responder_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, READY} resp_state_t;

    localparam logic [15:0] MEM_POISON = 16'hDEAD;
    localparam int          LAT_CNT_W  = 4;

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory bus: the CPU is the master and holds its request until memory_ready.
interface mem_responder_if;
    logic [15:0] addr;
    logic [15:0] wr_data;
    logic        memory_w;
    logic        memory_ready;
    logic [15:0] rd_data;
    logic        mem_error;

    modport master (output addr, wr_data, memory_w, input memory_ready, rd_data, mem_error);
    modport slave  (input addr, wr_data, memory_w, output memory_ready, rd_data, mem_error);
endinterface

// File: rtl/mem_array.sv
// Single-port 2^ADDR_W x 16 RAM with a registered read; a write returns its own data.
module mem_array #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);
    logic [15:0] mem [2**ADDR_W];

    // Storage is deliberately kept out of reset.
    always_ff @(posedge clk)
        if (en && we) mem[addr] <= wdata;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)  rdata <= '0;
        else if (en) rdata <= we ? wdata : mem[addr];
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: capture/wait/ready FSM in front of mem_array.
// Optional out-of-range checking of addr[15:ADDR_W] under MEM_RESPONDER_RANGE_CHECK_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 2
) (
    input logic            clk,
    input logic            rst_n,
    mem_responder_if.slave bus
);
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_responder: LATENCY must be in 1..15");
    end

    resp_state_t          state, state_nx;
    logic [LAT_CNT_W-1:0] cnt, cnt_nx;
    logic [15:0]          req_addr, req_wdata;
    logic                 req_w;
    logic [15:0]          eff_addr, eff_wdata;
    logic                 eff_w;
    logic                 fire, oor, ready_q;
    logic [15:0]          arr_rdata;

    // With LATENCY=1 the access fires on the capture edge, so the array must see the live bus.
    assign eff_addr  = (state == IDLE) ? bus.addr     : req_addr;
    assign eff_wdata = (state == IDLE) ? bus.wr_data  : req_wdata;
    assign eff_w     = (state == IDLE) ? bus.memory_w : req_w;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        fire     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = LAT_CNT_W'(LATENCY - 1);
                if (LATENCY == 1) begin
                    state_nx = READY;
                    fire     = 1'b1;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                // Fire on the edge that takes the counter to zero.
                cnt_nx = cnt - 1'b1;
                if (cnt == LAT_CNT_W'(1)) begin
                    state_nx = READY;
                    fire     = 1'b1;
                end
            end
            READY:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_w     <= 1'b0;
        end else if (state == IDLE) begin
            req_addr  <= bus.addr;
            req_wdata <= bus.wr_data;
            req_w     <= bus.memory_w;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= fire;

    assign bus.memory_ready = ready_q;

    mem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fire),
        .we    (eff_w && !oor),
        .addr  (eff_addr[ADDR_W-1:0]),
        .wdata (eff_wdata),
        .rdata (arr_rdata)
    );

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    logic err_q;

    assign oor = |(eff_addr >> ADDR_W);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= fire && oor;

    assign bus.mem_error = err_q;
    assign bus.rd_data   = err_q ? MEM_POISON : arr_rdata;
`else
    // Upper address bits alias in this build.
    logic addr_hi_unused;
    assign addr_hi_unused = |(eff_addr >> ADDR_W);
    assign oor            = 1'b0;
    assign bus.mem_error  = 1'b0;
    assign bus.rd_data    = arr_rdata;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three configurations checked against a periodic access model.
module tb_mem_responder;
    localparam int NI = 3;
    localparam int LAT [NI] = '{2, 1, 3};
    localparam int AW  [NI] = '{16, 16, 8};
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] t_addr [NI], t_wd [NI], t_rdd [NI];
    logic        t_w [NI], t_rdy [NI], t_err [NI];

    mem_responder_if bus [NI] ();

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign bus[g].addr     = t_addr[g];
        assign bus[g].wr_data  = t_wd[g];
        assign bus[g].memory_w = t_w[g];
        assign t_rdy[g] = bus[g].memory_ready;
        assign t_rdd[g] = bus[g].rd_data;
        assign t_err[g] = bus[g].mem_error;
        mem_responder #(.ADDR_W(AW[g]), .LATENCY(LAT[g])) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus[g])
        );
    end

    int n_tot = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s u%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
    endtask

    // Model: after reset the responder runs with period LAT+1; phase 0 captures the bus,
    // phase LAT is the ready cycle, where the access takes effect.
    logic [15:0] mdl [int];
    int          ph [NI];
    logic        cw [NI];
    logic [15:0] ca [NI], cd [NI];

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                ph[i] = 0;
                chk("rst_ready", i, 16'(t_rdy[i]), 16'd0);
                chk("rst_rd", i, t_rdd[i], 16'h0000);
                chk("rst_err", i, 16'(t_err[i]), 16'd0);
            end else begin
                if (ph[i] == 0) begin
                    cw[i] = t_w[i]; ca[i] = t_addr[i]; cd[i] = t_wd[i];
                end
                if (ph[i] == LAT[i]) begin
                    int  key;
                    bit  o;
                    key = i * 65536 + (int'(ca[i]) & ((1 << AW[i]) - 1));
                    o   = RANGE_EN && ((ca[i] >> AW[i]) != 16'h0);
                    chk("ready", i, 16'(t_rdy[i]), 16'd1);
                    chk("err", i, 16'(t_err[i]), 16'(o));
                    if (o && !cw[i])        chk("rd_poison", i, t_rdd[i], 16'hDEAD);
                    else if (cw[i] && !o)   chk("rd_wecho", i, t_rdd[i], cd[i]);
                    else if (!cw[i] && mdl.exists(key)) chk("rd_data", i, t_rdd[i], mdl[key]);
                    if (cw[i] && !o) mdl[key] = cd[i];
                    ph[i] = 0;
                end else begin
                    chk("ready_idle", i, 16'(t_rdy[i]), 16'd0);
                    ph[i] = ph[i] + 1;
                end
            end
        end
    end

    // One full access window, entered at posedge+2 of a phase-0 cycle.
    task automatic access(input int i, input logic w, input logic [15:0] a, input logic [15:0] d,
                          output logic rdy, output logic [15:0] rd, output logic er);
        t_w[i] = w; t_addr[i] = a; t_wd[i] = d;
        rdy = 1'b0; rd = '0; er = 1'b0;
        for (int k = 0; k <= LAT[i]; k++) begin
            @(negedge clk);
            if (k == LAT[i]) begin rdy = t_rdy[i]; rd = t_rdd[i]; er = t_err[i]; end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic seq0();
        logic r, e; logic [15:0] d;
        access(0, 1'b0, 16'h0010, 16'h0, r, d, e);
        chk("lit_rd_after_rst", 0, d, 16'h1111);
        access(0, 1'b1, 16'h0020, 16'h1234, r, d, e);
        chk("lit_w20_ready", 0, 16'(r), 16'd1);
        access(0, 1'b0, 16'h0020, 16'h0, r, d, e);
        chk("lit_r20", 0, d, 16'h1234);
        for (int n = 0; n < 4; n++) access(0, 1'b1, 16'h0030, 16'h00AA, r, d, e);
        access(0, 1'b0, 16'h0030, 16'h0, r, d, e);
        chk("lit_held_w30", 0, d, 16'h00AA);
    endtask

    task automatic seq1();
        logic r, e; logic [15:0] d;
        access(1, 1'b1, 16'hFFFF, 16'hCAFE, r, d, e);
        access(1, 1'b1, 16'hFFFE, 16'hBEEF, r, d, e);
        access(1, 1'b0, 16'hFFFF, 16'h0, r, d, e);
        chk("lit_rFFFF", 1, d, 16'hCAFE);
        access(1, 1'b0, 16'hFFFE, 16'h0, r, d, e);
        chk("lit_rFFFE", 1, d, 16'hBEEF);
        chk("lit_rFFFE_ready", 1, 16'(r), 16'd1);
        for (int n = 0; n < 5; n++) access(1, 1'b1, 16'h0030, 16'h00AA, r, d, e);
        access(1, 1'b0, 16'h0030, 16'h0, r, d, e);
        chk("lit_held_w30", 1, d, 16'h00AA);
    endtask

    task automatic seq2();
        logic r, e; logic [15:0] d;
        access(2, 1'b1, 16'h0005, 16'h0BAD, r, d, e);
        access(2, 1'b1, 16'h0105, 16'h7777, r, d, e);
        chk("lit_w105_err", 2, 16'(e), 16'(RANGE_EN));
        access(2, 1'b0, 16'h0105, 16'h0, r, d, e);
        chk("lit_r105", 2, d, RANGE_EN ? 16'hDEAD : 16'h7777);
        chk("lit_r105_err", 2, 16'(e), 16'(RANGE_EN));
        access(2, 1'b0, 16'h0005, 16'h0, r, d, e);
        chk("lit_r005", 2, d, RANGE_EN ? 16'h0BAD : 16'h7777);
    endtask

    initial begin
        logic r, e; logic [15:0] d;
        for (int i = 0; i < NI; i++) begin t_addr[i] = '0; t_wd[i] = '0; t_w[i] = 1'b0; end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        access(0, 1'b1, 16'h0010, 16'h1111, r, d, e);
        chk("lit_w10_ready", 0, 16'(r), 16'd1);
        chk("lit_w10_echo", 0, d, 16'h1111);
        // Start a write to 0x0010 and kill it in WAIT.
        t_w[0] = 1'b1; t_addr[0] = 16'h0010; t_wd[0] = 16'h2222;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_async_ready", 0, 16'(t_rdy[0]), 16'd0);
        chk("lit_async_rd", 0, t_rdd[0], 16'h0000);
        chk("lit_async_err", 0, 16'(t_err[0]), 16'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        fork
            seq0();
            seq1();
            seq2();
        join
        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
